// File: rtl/drive_sup_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drive_sup_pkg: supervisor state encodings and default threshold constants
// Rev 1.0
// ----------------------------------------------------------------------------
package drive_sup_pkg;

  localparam logic [2:0] ST_OFF     = 3'd0;
  localparam logic [2:0] ST_RUN     = 3'd1;
  localparam logic [2:0] ST_RAMP    = 3'd2;
  localparam logic [2:0] ST_LOCKOUT = 3'd3;

  localparam int unsigned DEF_BATT_W       = 12;
  localparam int unsigned DEF_SPD_W        = 11;
  localparam int unsigned DEF_BATT_LOW_TH  = 'h800;
  localparam int unsigned DEF_BATT_CRIT_TH = 'h700;
  localparam int unsigned DEF_BATT_HYST    = 'h040;
  localparam int unsigned DEF_DEB_SAMPLES  = 8;
  localparam int unsigned DEF_OVR_HOLD     = 16;
  localparam int unsigned DEF_RAMP_STEP    = 16;

endpackage
`default_nettype wire

// File: rtl/hyst_deb_cmp.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hyst_deb_cmp: vld-qualified threshold compare with hysteresis and debounce
// Rev 1.0
// ----------------------------------------------------------------------------
module hyst_deb_cmp
  import drive_sup_pkg::*;
#(
  parameter int unsigned W    = DEF_BATT_W,
  parameter int unsigned TH   = DEF_BATT_LOW_TH,
  parameter int unsigned HYST = DEF_BATT_HYST,
  parameter int unsigned DEB  = DEF_DEB_SAMPLES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         vld,
  input  logic [W-1:0] din,
  output logic         flag
);

  localparam int unsigned CW       = $clog2(DEB + 1);
  localparam logic [W-1:0] TH_V    = W'(TH);
  localparam logic [W:0]   TH_EXT  = (W+1)'(TH);
  localparam logic [W:0]   HY_EXT  = (W+1)'(HYST);
  localparam logic [W:0]   CLR_TH  = TH_EXT + HY_EXT;
  // A clear threshold beyond the sample range can never be reached.
  localparam logic         CLR_EN  = ~CLR_TH[W];
  localparam logic [CW-1:0] DEB_LAST = CW'(DEB - 1);

  logic          flag_q, flag_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          below_w, above_w, qual_w;

  assign below_w = (din < TH_V);
  assign above_w = CLR_EN && ({1'b0, din} >= CLR_TH);
  assign qual_w  = flag_q ? above_w : below_w;

  always_comb begin
    flag_d = flag_q;
    cnt_d  = cnt_q;
    if (vld) begin
      if (qual_w) begin
        if (cnt_q == DEB_LAST) begin
          flag_d = ~flag_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      flag_q <= flag_d;
      cnt_q  <= cnt_d;
    end
  end

  assign flag = flag_q;

endmodule
`default_nettype wire

// File: rtl/drive_supervisor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// drive_supervisor: battery/over-speed supervision and motor command gating
// Rev 1.0
// ----------------------------------------------------------------------------
module drive_supervisor
  import drive_sup_pkg::*;
#(
  parameter int unsigned BATT_W       = DEF_BATT_W,
  parameter int unsigned SPD_W        = DEF_SPD_W,
  parameter int unsigned BATT_LOW_TH  = DEF_BATT_LOW_TH,
  parameter int unsigned BATT_CRIT_TH = DEF_BATT_CRIT_TH,
  parameter int unsigned BATT_HYST    = DEF_BATT_HYST,
  parameter int unsigned DEB_SAMPLES  = DEF_DEB_SAMPLES,
  parameter int unsigned OVR_HOLD     = DEF_OVR_HOLD,
  parameter int unsigned RAMP_STEP    = DEF_RAMP_STEP
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pwr_up,
  input  logic              vld,
  input  logic [BATT_W-1:0] batt,
  input  logic              too_fast,
  input  logic              en_steer,
  input  logic [SPD_W-1:0]  lft_spd_in,
  input  logic [SPD_W-1:0]  rght_spd_in,
  input  logic              lft_rev_in,
  input  logic              rght_rev_in,
  output logic [SPD_W-1:0]  lft_spd,
  output logic [SPD_W-1:0]  rght_spd,
  output logic              lft_rev,
  output logic              rght_rev,
  output logic              batt_low,
  output logic              batt_crit,
  output logic              ovr_spd,
  output logic              moving,
  output logic [2:0]        state
);

  localparam int unsigned    OW       = $clog2(OVR_HOLD + 1);
  localparam logic [OW-1:0]  OVR_LAST = OW'(OVR_HOLD - 1);
  localparam logic [SPD_W-1:0] STEP_V = SPD_W'(RAMP_STEP);

  hyst_deb_cmp #(
    .W    (BATT_W),
    .TH   (BATT_LOW_TH),
    .HYST (BATT_HYST),
    .DEB  (DEB_SAMPLES)
  ) u_low (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (vld),
    .din   (batt),
    .flag  (batt_low)
  );

  hyst_deb_cmp #(
    .W    (BATT_W),
    .TH   (BATT_CRIT_TH),
    .HYST (BATT_HYST),
    .DEB  (DEB_SAMPLES)
  ) u_crit (
    .clk   (clk),
    .rst_n (rst_n),
    .vld   (vld),
    .din   (batt),
    .flag  (batt_crit)
  );

  logic [2:0]       state_q, state_d;
  logic [SPD_W-1:0] ramp_q, ramp_d;
  logic [SPD_W-1:0] lft_spd_q, lft_spd_d, rght_spd_q, rght_spd_d;
  logic             lft_rev_q, lft_rev_d, rght_rev_q, rght_rev_d;
  logic             moving_q, moving_d;
  logic             ovr_q, ovr_d;
  logic [OW-1:0]    ovr_cnt_q, ovr_cnt_d;
  logic [SPD_W-1:0] max_in_w, ramp_dec_w;

  assign max_in_w   = (lft_spd_in > rght_spd_in) ? lft_spd_in : rght_spd_in;
  assign ramp_dec_w = (ramp_q > STEP_V) ? (ramp_q - STEP_V) : '0;

  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    case (state_q)
      ST_OFF: begin
        if (pwr_up) state_d = batt_crit ? ST_LOCKOUT : ST_RUN;
      end
      ST_RUN: begin
        if (!pwr_up || batt_crit) begin
          state_d = ST_RAMP;
          ramp_d  = max_in_w;
        end
      end
      ST_RAMP: begin
        // Once started the ramp always completes; exit sees pwr_up first.
        if (ramp_q == '0) begin
          state_d = pwr_up ? ST_LOCKOUT : ST_OFF;
        end else if (vld) begin
          ramp_d = ramp_dec_w;
        end
      end
      ST_LOCKOUT: begin
        if (!pwr_up)        state_d = ST_OFF;
        else if (!batt_crit) state_d = ST_RUN;
      end
      default: state_d = ST_OFF;
    endcase
  end

  // Gate on the next state so outputs and state change on the same edge.
  always_comb begin
    lft_spd_d  = '0;
    rght_spd_d = '0;
    lft_rev_d  = 1'b0;
    rght_rev_d = 1'b0;
    case (state_d)
      ST_RUN: begin
        lft_spd_d  = lft_spd_in;
        rght_spd_d = rght_spd_in;
        lft_rev_d  = lft_rev_in;
        rght_rev_d = rght_rev_in;
      end
      ST_RAMP: begin
        lft_spd_d  = (lft_spd_in < ramp_d) ? lft_spd_in : ramp_d;
        rght_spd_d = (rght_spd_in < ramp_d) ? rght_spd_in : ramp_d;
        lft_rev_d  = lft_rev_in;
        rght_rev_d = rght_rev_in;
      end
      default: begin
        lft_spd_d  = '0;
        rght_spd_d = '0;
      end
    endcase
    moving_d = en_steer && (state_d == ST_RUN);
  end

  always_comb begin
    ovr_d     = ovr_q;
    ovr_cnt_d = ovr_cnt_q;
    if (vld) begin
      if (too_fast) begin
        ovr_d     = 1'b1;
        ovr_cnt_d = '0;
      end else if (ovr_q) begin
        if (ovr_cnt_q == OVR_LAST) begin
          ovr_d     = 1'b0;
          ovr_cnt_d = '0;
        end else begin
          ovr_cnt_d = ovr_cnt_q + OW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      ramp_q     <= '0;
      lft_spd_q  <= '0;
      rght_spd_q <= '0;
      lft_rev_q  <= 1'b0;
      rght_rev_q <= 1'b0;
      moving_q   <= 1'b0;
      ovr_q      <= 1'b0;
      ovr_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      ramp_q     <= ramp_d;
      lft_spd_q  <= lft_spd_d;
      rght_spd_q <= rght_spd_d;
      lft_rev_q  <= lft_rev_d;
      rght_rev_q <= rght_rev_d;
      moving_q   <= moving_d;
      ovr_q      <= ovr_d;
      ovr_cnt_q  <= ovr_cnt_d;
    end
  end

  assign lft_spd  = lft_spd_q;
  assign rght_spd = rght_spd_q;
  assign lft_rev  = lft_rev_q;
  assign rght_rev = rght_rev_q;
  assign moving   = moving_q;
  assign ovr_spd  = ovr_q;
  assign state    = state_q;

endmodule
`default_nettype wire

// File: tb/tb_drive_supervisor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_drive_supervisor: directed self-checking bench for drive_supervisor
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_drive_supervisor;

  logic        clk = 1'b0;
  logic        rst_n, pwr_up, vld, too_fast, en_steer;
  logic [11:0] batt;
  logic [10:0] lft_spd_in, rght_spd_in;
  logic        lft_rev_in, rght_rev_in;
  logic [10:0] lft_spd, rght_spd;
  logic        lft_rev, rght_rev, batt_low, batt_crit, ovr_spd, moving;
  logic [2:0]  state;

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  drive_supervisor #(
    .DEB_SAMPLES (4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_up      (pwr_up),
    .vld         (vld),
    .batt        (batt),
    .too_fast    (too_fast),
    .en_steer    (en_steer),
    .lft_spd_in  (lft_spd_in),
    .rght_spd_in (rght_spd_in),
    .lft_rev_in  (lft_rev_in),
    .rght_rev_in (rght_rev_in),
    .lft_spd     (lft_spd),
    .rght_spd    (rght_spd),
    .lft_rev     (lft_rev),
    .rght_rev    (rght_rev),
    .batt_low    (batt_low),
    .batt_crit   (batt_crit),
    .ovr_spd     (ovr_spd),
    .moving      (moving),
    .state       (state)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic sample(input logic [11:0] b, input logic tf);
    batt     = b;
    too_fast = tf;
    vld      = 1'b1;
    @(negedge clk);
    vld      = 1'b0;
    too_fast = 1'b0;
  endtask

  initial begin
    int r;
    rst_n = 1'b0; pwr_up = 1'b0; vld = 1'b0; too_fast = 1'b0; en_steer = 1'b0;
    batt = 12'hFFF; lft_spd_in = '0; rght_spd_in = '0;
    lft_rev_in = 1'b0; rght_rev_in = 1'b0;
    step(); step();
    chk("rst_state", state, 0);
    chk("rst_lft", lft_spd, 0);
    chk("rst_flags", {batt_low, batt_crit, ovr_spd, moving}, 0);
    rst_n = 1'b1;
    step();

    // Low-battery debounce and hysteresis band
    for (int i = 0; i < 3; i++) sample(12'h7FF, 1'b0);
    sample(12'h820, 1'b0);
    chk("low_interrupted", batt_low, 0);
    for (int i = 0; i < 3; i++) sample(12'h7FF, 1'b0);
    chk("low_after3", batt_low, 0);
    sample(12'h7FF, 1'b0);
    chk("low_after4", batt_low, 1);
    for (int i = 0; i < 4; i++) sample(12'h820, 1'b0);
    chk("low_in_band", batt_low, 1);
    for (int i = 0; i < 3; i++) sample(12'h840, 1'b0);
    chk("low_clr_after3", batt_low, 1);
    sample(12'h840, 1'b0);
    chk("low_clr_after4", batt_low, 0);
    chk("crit_never_set", batt_crit, 0);

    // Power-up pass-through and power-down ramp
    batt = 12'hFFF; lft_spd_in = 300; rght_spd_in = 200; en_steer = 1'b1;
    pwr_up = 1'b1;
    step();
    chk("run_state", state, 1);
    chk("run_lft", lft_spd, 300);
    chk("run_rght", rght_spd, 200);
    chk("run_moving", moving, 1);
    lft_spd_in = 310; lft_rev_in = 1'b1;
    step();
    chk("run_lat_lft", lft_spd, 310);
    chk("run_lat_rev", lft_rev, 1);
    lft_spd_in = 300; lft_rev_in = 1'b0;
    step();
    pwr_up = 1'b0;
    step();
    chk("ramp_state", state, 2);
    chk("ramp_entry_lft", lft_spd, 300);
    chk("ramp_moving", moving, 0);
    for (int k = 1; k <= 19; k++) begin
      sample(12'hFFF, 1'b0);
      r = (300 > 16 * k) ? 300 - 16 * k : 0;
      chk($sformatf("ramp_lft_%0d", k), lft_spd, (r < 300) ? r : 300);
      chk($sformatf("ramp_rght_%0d", k), rght_spd, (r < 200) ? r : 200);
    end
    chk("ramp_hold_state", state, 2);
    step();
    chk("ramp_to_off", state, 0);

    // Critical battery while running -> ramp -> lockout -> recovery
    pwr_up = 1'b1;
    step();
    chk("run2_state", state, 1);
    for (int i = 0; i < 4; i++) sample(12'h6FF, 1'b0);
    chk("crit_set", batt_crit, 1);
    chk("crit_run_still", state, 1);
    step();
    chk("crit_ramp", state, 2);
    for (int i = 0; i < 19; i++) sample(12'h6FF, 1'b0);
    step();
    chk("lockout_state", state, 3);
    chk("lockout_lft", lft_spd, 0);
    chk("lockout_rght", rght_spd, 0);
    for (int i = 0; i < 4; i++) sample(12'h800, 1'b0);
    chk("crit_clr", batt_crit, 0);
    chk("low_band_hold", batt_low, 1);
    step();
    chk("lockout_to_run", state, 1);
    chk("relock_lft", lft_spd, 300);

    // Over-speed stretch
    sample(12'h800, 1'b1);
    chk("ovr_set", ovr_spd, 1);
    for (int i = 0; i < 15; i++) sample(12'h800, 1'b0);
    chk("ovr_hold15", ovr_spd, 1);
    sample(12'h800, 1'b0);
    chk("ovr_clr16", ovr_spd, 0);
    sample(12'h800, 1'b1);
    for (int i = 0; i < 9; i++) sample(12'h800, 1'b0);
    sample(12'h800, 1'b1);
    for (int i = 0; i < 15; i++) sample(12'h800, 1'b0);
    chk("ovr_restart15", ovr_spd, 1);
    sample(12'h800, 1'b0);
    chk("ovr_restart16", ovr_spd, 0);

    // Reset in the middle of a ramp
    lft_spd_in = 150; rght_spd_in = 100;
    step();
    pwr_up = 1'b0;
    step();
    chk("mid_ramp_state", state, 2);
    lft_spd_in = 400;
    step();
    chk("ramp_limit", lft_spd, 150);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_state", state, 0);
    chk("async_rst_spd", {lft_spd, rght_spd}, 0);
    chk("async_rst_flags", {batt_low, batt_crit, ovr_spd, moving}, 0);
    @(negedge clk);
    rst_n = 1'b1; pwr_up = 1'b1;
    step();
    chk("post_rst_run", state, 1);
    chk("post_rst_nolimit", lft_spd, 400);

    // pwr_up fall coinciding with batt_crit rise
    lft_spd_in = 32; rght_spd_in = 32;
    step();
    for (int i = 0; i < 4; i++) sample(12'h6FF, 1'b0);
    chk("sim_crit", batt_crit, 1);
    pwr_up = 1'b0;
    step();
    chk("sim_ramp", state, 2);
    sample(12'h6FF, 1'b0);
    sample(12'h6FF, 1'b0);
    chk("sim_ramp_zero", lft_spd, 0);
    step();
    chk("sim_exit_off", state, 0);
    step();
    chk("sim_stay_off", state, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
